td4_exec_ctrl: RTL and testbench
================================

// Module: td4_exec_ctrl
// PURPOSE
//  Execution controller sitting directly upstream of the four IC74HC161_L-style 4-bit registers (A, B, OUT, PC).
//  Decodes the 8-bit TD4 instruction from ROM and selects the source operand (A, B, IN, 0).
//  Adds the immediate, holds the carry flag, and drives the shared 4-bit data bus plus the active-low loads.
//  Paces execution: free-run at a divided rate, or single-step from a debounced button.
// PARAMETERS
//  CLK_DIV  4  clk cycles per executed instruction in run mode (>=1; 1 = every cycle)
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  rst        in   1  synchronous reset, active-high
//  inst       in   8  instruction at current PC: [7:4] opcode, [3:0] immediate
//  reg_a      in   4  current A register value
//  reg_b      in   4  current B register value
//  in_port    in   4  external input port
//  mode_step  in   1  0 = run (divided), 1 = single-step
//  step_btn   in   1  asynchronous step button, active-high, already debounced
//  alu_out    out  4  data bus to all register 'in' ports = (src + imm)[3:0]
//  load_n     out  4  active-low loads: [0]=A [1]=B [2]=OUT [3]=PC
//  pc_inc     out  1  PC count enable (high on exec cycles that do not load PC)
//  carry      out  1  carry flag register
//  exec       out  1  registered execute strobe, one clk wide
// BEHAVIOUR
//  Clocking and reset
//   - Single clock domain; rst takes effect at the next clk edge.
//   - Reset values: exec=0, carry=0, load_n=4'b1111, pc_inc=0.
//   - Internal state cleared by reset: div counter=0, step synchroniser=0, FSM=IDLE.
//   - rst asserted mid-operation aborts any pending strobe; no load_n is asserted during the reset cycle.
//  Pacing FSM (RUN, IDLE, ARMED)
//   - RUN (mode_step=0): counter runs 0..CLK_DIV-1; exec=1 for the one cycle after the counter wraps to 0.
//     First exec occurs CLK_DIV cycles after rst deasserts.
//   - mode_step=1 -> IDLE. Counter held at 0.
//   - Step capture: step_btn passes through a 2-FF synchroniser; a rising edge of the synchronised signal -> ARMED.
//   - ARMED: exec=1 for exactly one cycle, then back to IDLE. A held button yields exactly one exec.
//   - mode_step 0->1 mid-count: counter cleared, no exec that cycle.
//   - mode_step 1->0: enter RUN with counter=0.
//   - A step edge arriving while in RUN is ignored.
//  Decode (combinational from inst)
//   - Source select: 00=A, 01=B, 10=in_port, 11=4'h0.
//   - alu_out = (src + imm) mod 16; cout = bit 4 of the 5-bit sum.
//   - Opcode -> source, destination:
//       0000 A+im->A   0001 B->A    0010 IN->A   0011 im->A
//       0100 A->B      0101 B+im->B 0110 IN->B   0111 im->B
//       1001 B+im->OUT 1011 im->OUT 1111 im->PC (JMP)
//       1110 im->PC only if carry==0 (JNC)
//   - Opcodes 1000, 1010, 1100, 1101: NOP, with no register load.
//   - MOV forms carry imm=0000 in encoding; the adder is always in the path.
//  Outputs
//   - load_n bit is low only when exec=1 and the opcode targets that register; otherwise all load_n bits are 1.
//   - pc_inc = exec & ~(PC loaded this cycle). JNC not taken -> pc_inc=1.
//   - carry <= cout on every exec cycle, including NOP/JMP/JNC (for im-source ops this is 0); held otherwise.
//   - JNC tests the carry value before that cycle's update.
//  Latency and bus
//   - Registers capture alu_out on the clk edge ending the exec cycle.
//   - alu_out is valid (combinational) at all times; consumers honour only load_n.
// TESTING
//  1. rst=1 for 3 cycles -> exec=0, load_n=1111, carry=0, pc_inc=0 throughout.
//  2. CLK_DIV=4, mode_step=0, inst=0x33 -> exec every 4th cycle, load_n=1110, alu_out=3, pc_inc=1.
//  3. reg_a=0xE, inst=0x03 -> alu_out=0x1, carry=1 after exec.
//     Then inst=0xE5 (JNC 5) -> load_n=1111, pc_inc=1 (not taken); carry then updates to 0.
//  4. carry=0, inst=0xE7 -> load_n=0111, alu_out=7, pc_inc=0. inst=0xF9 -> load_n=0111, alu_out=9.
//  5. mode_step=1, step_btn held high 10 cycles -> exactly one exec, 3 cycles after the rising edge.
//     Release and press again -> one more exec.
//  6. inst=0x80 (NOP) -> load_n=1111, pc_inc=1; rst asserted on an exec cycle -> no load_n low, carry=0.

Source files
------------

// File: rtl/td4_exec_ctrl.sv
// td4_exec_ctrl
// Execution controller for a TD4-style 4-bit CPU. It decodes the ROM
// instruction, selects the source operand, adds the immediate, keeps the
// carry flag and drives the shared data bus plus the active-low register
// loads. A pacing FSM decides when an instruction executes. In run mode it
// fires once every CLK_DIV clocks. In single-step mode it fires once per
// press of the debounced step button.
//
// Interface timing: exec is a one-clock strobe. Registers downstream capture
// alu_out on the clk edge that ends the exec cycle, and only where the
// matching load_n bit is low. alu_out itself is combinational at all times.
// dbg_state exposes the pacing FSM state to bound checkers.

module td4_exec_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inst,
  input  logic [3:0] reg_a,
  input  logic [3:0] reg_b,
  input  logic [3:0] in_port,
  input  logic       mode_step,
  input  logic       step_btn,
  output logic [3:0] alu_out,
  output logic [3:0] load_n,
  output logic       pc_inc,
  output logic       carry,
  output logic       exec,
  output logic [1:0] dbg_state
);

  // Divider counter width. A width of at least one bit keeps CLK_DIV=1 legal.
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sync_q;     // [0],[1] = two-flop synchroniser, [2] = edge history
  logic          step_rise;
  logic          exec_q, exec_d;
  logic          carry_q;

  // Decode signals
  logic [3:0] opcode;
  logic [3:0] imm;
  logic [1:0] src_sel;
  logic [3:0] src_val;
  logic [4:0] sum;
  logic       ld_a, ld_b, ld_out, ld_jmp, is_jnc;
  logic       pc_load;
  logic       exec_v;

  assign step_rise = sync_q[1] & ~sync_q[2];

  // Pacing FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Pacing FSM next-state logic. A step edge is honoured only from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!mode_step)     state_d = ST_RUN;
        else if (step_rise) state_d = ST_ARMED;
      end
      ST_RUN: begin
        if (mode_step) state_d = ST_IDLE;
      end
      ST_ARMED: begin
        state_d = mode_step ? ST_IDLE : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pacing FSM outputs: divider count and the execute request.
  // The counter counts only in run mode and is held at zero in step mode,
  // so a switch back to run mode always starts a fresh CLK_DIV period.
  always_comb begin
    cnt_d  = '0;
    exec_d = 1'b0;
    if (!mode_step) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        exec_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (state_q == ST_IDLE && step_rise) begin
      exec_d = 1'b1;
    end
  end

  // Divider, step synchroniser and registered execute strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sync_q <= 3'b000;
      exec_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= {sync_q[1:0], step_btn};
      exec_q <= exec_d;
    end
  end

  assign opcode = inst[7:4];
  assign imm    = inst[3:0];

  // Instruction decode: source select, adder, destination flags.
  // JNC is encoded with select field 10, but it adds the immediate to zero.
  always_comb begin
    src_sel = opcode[1:0];
    if (opcode == 4'b1110) src_sel = 2'b11;
    case (src_sel)
      2'b00:   src_val = reg_a;
      2'b01:   src_val = reg_b;
      2'b10:   src_val = in_port;
      default: src_val = 4'h0;
    endcase
    sum    = {1'b0, src_val} + {1'b0, imm};
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    ld_out = 1'b0;
    ld_jmp = 1'b0;
    is_jnc = 1'b0;
    case (opcode)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: ld_a   = 1'b1;
      4'b0100, 4'b0101, 4'b0110, 4'b0111: ld_b   = 1'b1;
      4'b1001, 4'b1011:                   ld_out = 1'b1;
      4'b1111:                            ld_jmp = 1'b1;
      4'b1110:                            is_jnc = 1'b1;
      default: ;  // 1000, 1010, 1100, 1101 are NOPs
    endcase
  end

  // Strobe is masked during a reset cycle so that no load can escape.
  assign exec_v  = exec_q & ~rst;
  // JNC tests the carry held before this cycle's update.
  assign pc_load = ld_jmp | (is_jnc & ~carry_q);

  // Register load strobes and PC count enable
  always_comb begin
    load_n = 4'b1111;
    pc_inc = 1'b0;
    if (exec_v) begin
      load_n = ~{pc_load, ld_out, ld_b, ld_a};
      pc_inc = ~pc_load;
    end
  end

  // Carry flag: updated from the adder on every exec cycle, held otherwise
  always_ff @(posedge clk) begin
    if (rst)         carry_q <= 1'b0;
    else if (exec_q) carry_q <= sum[4];
  end

  assign alu_out   = sum[3:0];
  assign carry     = carry_q;
  assign exec      = exec_v;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_td4_exec_ctrl.sv
// tb_td4_exec_ctrl
// Bench for td4_exec_ctrl. It runs directed scenarios with hand-computed
// expectations, then a long randomized phase. Every cycle, a scoreboard
// compares all outputs against a behavioural timing/ALU model.

module tb_td4_exec_ctrl;

  localparam int CLK_DIV = 4;
  localparam int W       = 11;   // {exec, load_n[3:0], pc_inc, carry, alu_out[3:0]}
  localparam int MAXC    = 8192;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] inst;
  logic [3:0] reg_a, reg_b, in_port;
  logic       mode_step, step_btn;
  logic [3:0] alu_out, load_n;
  logic       pc_inc, carry, exec;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  td4_exec_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .inst(inst), .reg_a(reg_a), .reg_b(reg_b),
    .in_port(in_port), .mode_step(mode_step), .step_btn(step_btn),
    .alu_out(alu_out), .load_n(load_n), .pc_inc(pc_inc), .carry(carry),
    .exec(exec), .dbg_state(dbg_state)
  );

  int checks = 0;
  int passed = 0;
  int tcount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s @%0t: actual %0h required %0h", name, $time, act, req);
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  // Input history indexed by cycle number (cycle n runs from posedge n to
  // posedge n+1). Cycles before the first negedge count as reset cycles.
  bit h_rst  [0:MAXC-1];
  bit h_mode [0:MAXC-1];
  bit h_btn  [0:MAXC-1];
  int cyc     = 0;
  int run_len = 0;       // consecutive run-mode, non-reset cycles through cyc-1
  bit carry_m = 1'b0;
  logic [W-1:0] exp_q[$];

  function automatic bit hr(input int k);
    if (k < 1 || k >= MAXC) return 1'b1;
    return h_rst[k];
  endfunction
  function automatic bit hm(input int k);
    if (k < 1 || k >= MAXC) return 1'b1;
    return h_mode[k];
  endfunction
  function automatic bit hb(input int k);
    if (k < 1 || k >= MAXC) return 1'b0;
    return h_btn[k];
  endfunction

  // src: 0=A 1=B 2=IN 3=zero ; dst: 0=none 1=A 2=B 3=OUT 4=PC 5=PC-if-no-carry
  function automatic void model_decode(input logic [3:0] op, output int src, output int dst);
    case (op)
      4'h0: begin src = 0; dst = 1; end
      4'h1: begin src = 1; dst = 1; end
      4'h2: begin src = 2; dst = 1; end
      4'h3: begin src = 3; dst = 1; end
      4'h4: begin src = 0; dst = 2; end
      4'h5: begin src = 1; dst = 2; end
      4'h6: begin src = 2; dst = 2; end
      4'h7: begin src = 3; dst = 2; end
      4'h9: begin src = 1; dst = 3; end
      4'hB: begin src = 3; dst = 3; end
      4'hF: begin src = 3; dst = 4; end
      4'hE: begin src = 3; dst = 5; end
      4'h8: begin src = 0; dst = 0; end
      4'hA: begin src = 2; dst = 0; end
      4'hC: begin src = 0; dst = 0; end
      default: begin src = 1; dst = 0; end   // 4'hD
    endcase
  endfunction

  always @(negedge clk) begin
    int src, dst, sum;
    bit e, pcl;
    logic [3:0] eload;
    logic [W-1:0] expv, got;
    cyc++;
    if (cyc < MAXC) begin
      h_rst[cyc]  = rst;
      h_mode[cyc] = mode_step;
      h_btn[cyc]  = step_btn;
    end
    // Exec timing: in run mode, one exec per CLK_DIV run cycles. In step
    // mode, one exec three cycles after a button 0->1 transition, provided
    // that step mode was already in force when the edge was seen.
    e = 1'b0;
    if (!hr(cyc-1)) begin
      if (!hm(cyc-1) && run_len > 0 && (run_len % CLK_DIV) == 0) e = 1'b1;
      if (hm(cyc-1) && (hm(cyc-2) || hr(cyc-2)) && hb(cyc-3) && !hb(cyc-4)) e = 1'b1;
    end
    if (rst) e = 1'b0;
    model_decode(inst[7:4], src, dst);
    case (src)
      0: sum = int'(reg_a) + int'(inst[3:0]);
      1: sum = int'(reg_b) + int'(inst[3:0]);
      2: sum = int'(in_port) + int'(inst[3:0]);
      default: sum = int'(inst[3:0]);
    endcase
    pcl   = (dst == 4) || (dst == 5 && !carry_m);
    eload = 4'b1111;
    if (e) begin
      if (dst == 1) eload[0] = 1'b0;
      if (dst == 2) eload[1] = 1'b0;
      if (dst == 3) eload[2] = 1'b0;
      if (pcl)      eload[3] = 1'b0;
    end
    expv = {e, eload, e && !pcl, carry_m, 4'(sum % 16)};
    exp_q.push_back(expv);
    got  = {exec, load_n, pc_inc, carry, alu_out};
    if (exp_q.size() > 0) begin
      expv = exp_q.pop_front();
      check("sb_exec",    32'(got[10]),  32'(expv[10]));
      check("sb_load_n",  32'(got[9:6]), 32'(expv[9:6]));
      check("sb_pc_inc",  32'(got[5]),   32'(expv[5]));
      check("sb_carry",   32'(got[4]),   32'(expv[4]));
      check("sb_alu_out", 32'(got[3:0]), 32'(expv[3:0]));
    end
    // advance model state to the next cycle
    if (rst)    carry_m = 1'b0;
    else if (e) carry_m = (sum > 15);
    if (rst || mode_step) run_len = 0;
    else                  run_len++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    tcount++;
  endtask

  task automatic rand_data();
    inst    = 8'($urandom_range(0, 255));
    reg_a   = 4'($urandom_range(0, 15));
    reg_b   = 4'($urandom_range(0, 15));
    in_port = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_exec(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!exec && n < budget);
    if (!exec) check("exec_within_budget", 32'(exec), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, cnt, first_at;
    rst = 1'b1; mode_step = 1'b0; step_btn = 1'b0;
    inst = 8'h33; reg_a = 4'h0; reg_b = 4'h0; in_port = 4'h0;

    // reset held for three cycles
    repeat (3) begin
      tick();
      check("rst_exec",   32'(exec),   32'd0);
      check("rst_load_n", 32'(load_n), 32'hF);
      check("rst_carry",  32'(carry),  32'd0);
      check("rst_pc_inc", 32'(pc_inc), 32'd0);
    end
    rst = 1'b0;

    // run mode, im->A
    wait_exec(20, n);
    check("first_exec_latency", 32'(n), 32'(CLK_DIV));
    check("mov_a_load_n", 32'(load_n), 32'hE);
    check("mov_a_alu",    32'(alu_out), 32'h3);
    check("mov_a_pc_inc", 32'(pc_inc), 32'd1);
    wait_exec(20, n);
    check("run_period", 32'(n), 32'(CLK_DIV));

    // add with carry out, then JNC not taken
    tick();
    inst = 8'h03; reg_a = 4'hE;
    wait_exec(20, n);
    check("add_alu",    32'(alu_out), 32'h1);
    check("add_load_n", 32'(load_n), 32'hE);
    tick();
    check("add_carry_set", 32'(carry), 32'd1);
    inst = 8'hE5;
    wait_exec(20, n);
    check("jnc_nt_load_n", 32'(load_n), 32'hF);
    check("jnc_nt_pc_inc", 32'(pc_inc), 32'd1);
    tick();
    check("jnc_carry_clr", 32'(carry), 32'd0);

    // JNC taken, JMP
    inst = 8'hE7;
    wait_exec(20, n);
    check("jnc_t_load_n", 32'(load_n), 32'h7);
    check("jnc_t_alu",    32'(alu_out), 32'h7);
    check("jnc_t_pc_inc", 32'(pc_inc), 32'd0);
    tick();
    inst = 8'hF9;
    wait_exec(20, n);
    check("jmp_load_n", 32'(load_n), 32'h7);
    check("jmp_alu",    32'(alu_out), 32'h9);
    tick();

    // single step: held button gives one exec, 3 cycles after the edge
    mode_step = 1'b1;
    repeat (6) tick();
    step_btn = 1'b1;
    cnt = 0; first_at = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (exec) begin
        cnt++;
        if (first_at == 0) first_at = i;
      end
    end
    check("step_held_count", 32'(cnt), 32'd1);
    check("step_latency",    32'(first_at), 32'd3);
    step_btn = 1'b0;
    repeat (5) tick();
    step_btn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (exec) cnt++;
    end
    check("step_second_count", 32'(cnt), 32'd1);
    step_btn = 1'b0;
    repeat (5) tick();

    // NOP in run mode
    mode_step = 1'b0;
    inst = 8'h80;
    wait_exec(20, n);
    check("nop_load_n", 32'(load_n), 32'hF);
    check("nop_pc_inc", 32'(pc_inc), 32'd1);

    // reset landing on an exec cycle
    tick();
    inst = 8'h03; reg_a = 4'hE;
    wait_exec(20, n);
    tick();
    check("pre_rst_carry", 32'(carry), 32'd1);
    wait_exec(20, n);
    rst = 1'b1;
    #1;
    check("rst_exec_cycle_exec",   32'(exec),   32'd0);
    check("rst_exec_cycle_load_n", 32'(load_n), 32'hF);
    check("rst_exec_cycle_pc_inc", 32'(pc_inc), 32'd0);
    tick();
    check("rst_exec_cycle_carry",  32'(carry),  32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // randomized phase, checked by the scoreboard every cycle
    while (tcount < 3200) begin
      if ($urandom_range(0, 15) == 0) begin
        step_btn = 1'b0;
        repeat (5) begin rand_data(); tick(); end
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) begin rand_data(); tick(); end
        rst = 1'b0;
        mode_step = 1'($urandom_range(0, 1));
        repeat (5) begin rand_data(); tick(); end
      end else begin
        mode_step = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 40)) begin
          rand_data();
          if ($urandom_range(0, 3) == 0) step_btn = ~step_btn;
          tick();
        end
      end
    end

    repeat (2) tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
